// File: rtl/ncl_seq_pkg.sv
// Shared types and constants for the NCL counter sequencer: FSM state
// encoding, dual-rail digit codes and the default wait-state watchdog limit.
package ncl_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_WAIT_ACK,
        S_NULL,
        S_WAIT_NACK,
        S_DONE
    } seq_state_t;

    localparam logic [1:0] NCL_NULL = 2'b00;
    localparam logic [1:0] NCL_D0   = 2'b01;
    localparam logic [1:0] NCL_D1   = 2'b10;

    localparam int          WD_W     = 12;
    localparam logic [11:0] WD_LIMIT = 12'd4095;

endpackage

// File: rtl/ncl_sync2.sv
// Two-flop synchronizer for one asynchronous bit, cleared by init.
module ncl_sync2 (
    input  logic clk,
    input  logic init,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the raw bit through two flops before anyone downstream uses it.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ncl_counter_sequencer.sv
// Clocked sequencer for an asynchronous NCL dual-rail counter: issues bursts
// of DATA/NULL wavefronts on cin, and captures the dual-rail sum digits into
// a binary word with per-digit completion.
// Optional build macro: NCL_SEQ_TIMEOUT_EN adds a 12-bit watchdog that
// aborts a burst stuck in WAIT_ACK or WAIT_NACK.
//
//   state       | meaning
//   ------------+-----------------------------------------------------
//   S_IDLE      | ready for a command, cin NULL
//   S_DATA      | first cycle of a DATA wavefront on cin
//   S_WAIT_ACK  | cin held DATA until digit 0 acknowledges
//   S_NULL      | single cycle driving NULL on cin
//   S_WAIT_NACK | cin NULL until digit 0 releases its acknowledge
//   S_DONE      | burst finished, done pulse follows
module ncl_counter_sequencer
    import ncl_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 init,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [CNT_W-1:0]     cmd_count,
    input  logic                 cmd_inc,
    output logic [1:0]           cin,
    input  logic                 cin_ack,
    input  logic [2*WIDTH-1:0]   sum,
    output logic [WIDTH-1:0]     sum_ack,
    output logic                 word_valid,
    output logic [WIDTH-1:0]     word,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    logic                 ack_s;
    logic [2*WIDTH-1:0]   sum_s;

    seq_state_t           state, state_nxt;
    logic [CNT_W-1:0]     remaining, remaining_nxt;
    logic                 inc_r, inc_r_nxt;
    logic [1:0]           cin_nxt;
    logic                 wd_expired;

    logic [WIDTH-1:0]     cap, got, cap_now, rail1, ack_nxt;
    logic                 digit_bad;

    ncl_sync2 u_sync_ack (.clk(clk), .init(init), .d(cin_ack), .q(ack_s));

    for (genvar g = 0; g < 2*WIDTH; g++) begin : g_sync_sum
        ncl_sync2 u_sync_sum (.clk(clk), .init(init), .d(sum[g]), .q(sum_s[g]));
    end

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

`ifdef NCL_SEQ_TIMEOUT_EN
    logic [WD_W-1:0] wd_cnt;
    logic            in_wait;

    assign in_wait    = (state == S_WAIT_ACK) || (state == S_WAIT_NACK);
    assign wd_expired = in_wait && (wd_cnt == '0);

    // Down-count while waiting on digit 0; reload whenever a wait state is left.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            wd_cnt <= WD_LIMIT - 12'd1;
        end else if (!in_wait) begin
            wd_cnt <= WD_LIMIT - 12'd1;
        end else if (wd_cnt != '0) begin
            wd_cnt <= wd_cnt - 12'd1;
        end
    end
`else
    assign wd_expired = 1'b0;
`endif

    // Next-state, burst bookkeeping and the next cin value.
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        inc_r_nxt     = inc_r;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    remaining_nxt = cmd_count;
                    inc_r_nxt     = cmd_inc;
                    state_nxt     = (cmd_count == '0) ? S_DONE : S_DATA;
                end
            end
            S_DATA:      state_nxt = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (ack_s) begin
                    remaining_nxt = remaining - {{(CNT_W-1){1'b0}}, 1'b1};
                    state_nxt     = S_NULL;
                end
            end
            S_NULL:      state_nxt = S_WAIT_NACK;
            S_WAIT_NACK: begin
                if (!ack_s) state_nxt = (remaining != '0) ? S_DATA : S_DONE;
            end
            S_DONE:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
        if (wd_expired) begin
            state_nxt     = S_IDLE;
            remaining_nxt = '0;
        end
        cin_nxt = ((state_nxt == S_DATA) || (state_nxt == S_WAIT_ACK))
                  ? {inc_r_nxt, ~inc_r_nxt} : NCL_NULL;
    end

    // FSM registers; cin is registered so it can never glitch through 11.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state     <= S_IDLE;
            remaining <= '0;
            inc_r     <= 1'b0;
            cin       <= NCL_NULL;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            inc_r     <= inc_r_nxt;
            cin       <= cin_nxt;
            done      <= (state == S_DONE);
        end
    end

    // Per-digit completion: rise on DATA (capturing rail1), fall on NULL, hold on 11.
    always_comb begin
        ack_nxt   = sum_ack;
        cap_now   = '0;
        rail1     = '0;
        digit_bad = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            rail1[i] = sum_s[2*i+1];
            case (sum_s[2*i +: 2])
                NCL_NULL: ack_nxt[i] = 1'b0;
                NCL_D0, NCL_D1: begin
                    if (!sum_ack[i]) begin
                        ack_nxt[i] = 1'b1;
                        cap_now[i] = 1'b1;
                    end
                end
                default: digit_bad = 1'b1;
            endcase
        end
    end

    // Capture register and word assembly; a digit captured in the same cycle
    // as word_valid is credited to the following word.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            sum_ack    <= '0;
            cap        <= '0;
            got        <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            sum_ack <= ack_nxt;
            cap     <= (cap & ~cap_now) | (rail1 & cap_now);
            err     <= err | digit_bad | wd_expired;
            if (&got) begin
                word_valid <= 1'b1;
                word       <= cap;
                got        <= cap_now;
            end else begin
                word_valid <= 1'b0;
                got        <= got | cap_now;
            end
        end
    end

endmodule

// File: tb/tb_ncl_counter_sequencer.sv
// Bench for ncl_counter_sequencer: an ideal NCL counter responder plus
// arithmetic expectations for the words each burst should produce.
module tb_ncl_counter_sequencer;

   localparam int WIDTH = 32;
   localparam int CNT_W = 16;

   logic                 clk = 1'b0;
   logic                 init = 1'b1;
   logic                 cmd_valid = 1'b0;
   logic                 cmd_ready;
   logic [CNT_W-1:0]     cmd_count = '0;
   logic                 cmd_inc = 1'b0;
   logic [1:0]           cin;
   logic                 cin_ack = 1'b0;
   logic [2*WIDTH-1:0]   sum = '0;
   logic [WIDTH-1:0]     sum_ack;
   logic                 word_valid;
   logic [WIDTH-1:0]     word;
   logic                 busy;
   logic                 done;
   logic                 err;

   int errors = 0;
   int checks = 0;

   logic [WIDTH-1:0] model_val = '0;
   bit               resp_en = 1'b0;
   logic [WIDTH-1:0] obs_words[$];
   int               done_cnt = 0;
   int               data_cnt = 0;
   int               bad_cin = 0;
   logic [1:0]       prev_cin = 2'b00;

   ncl_counter_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .init(init), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_count(cmd_count), .cmd_inc(cmd_inc), .cin(cin), .cin_ack(cin_ack),
      .sum(sum), .sum_ack(sum_ack), .word_valid(word_valid), .word(word),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [2*WIDTH-1:0] dr(input logic [WIDTH-1:0] v);
      logic [2*WIDTH-1:0] r;
      for (int i = 0; i < WIDTH; i++) r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
      return r;
   endfunction

   // Ideal counter: adds the carry-in rail to its value on each DATA wavefront.
   initial begin
      forever begin
         @(negedge clk);
         if (resp_en && !init) begin
            if (!cin_ack && (cin == 2'b01 || cin == 2'b10)) begin
               model_val = model_val + {{(WIDTH-1){1'b0}}, cin[1]};
               repeat ($urandom_range(0, 3)) @(negedge clk);
               sum = dr(model_val);
               repeat ($urandom_range(1, 4)) @(negedge clk);
               cin_ack = 1'b1;
            end else if (cin_ack && cin == 2'b00) begin
               repeat ($urandom_range(0, 3)) @(negedge clk);
               sum = '0;
               repeat ($urandom_range(1, 4)) @(negedge clk);
               cin_ack = 1'b0;
            end
         end
      end
   end

   // Observation of words, done pulses and cin wavefronts.
   initial begin
      forever begin
         @(negedge clk);
         if (word_valid) obs_words.push_back(word);
         if (done) done_cnt++;
         if (cin != 2'b00 && prev_cin == 2'b00) data_cnt++;
         if (cin == 2'b11) bad_cin++;
         prev_cin = cin;
      end
   end

   task automatic clear_obs();
      obs_words.delete();
      done_cnt = 0;
      data_cnt = 0;
      bad_cin  = 0;
   endtask

   task automatic issue(input int cnt, input bit inc);
      @(negedge clk);
      cmd_count = cnt[CNT_W-1:0];
      cmd_inc   = inc;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      sum = dr(32'h1234_5678);
      repeat (3) @(negedge clk);
      checks++;
      if (cin !== 2'b00 || sum_ack !== '0 || word !== '0 || word_valid !== 1'b0 ||
          done !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset: cin=%b sum_ack=%h word=%h wv=%b done=%b err=%b busy=%b rdy=%b (want 00 0 0 0 0 0 0 1)",
                  cin, sum_ack, word, word_valid, done, err, busy, cmd_ready);
      end
      sum  = '0;
      init = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_zero_count();
      bit cin_ok = 1'b1;
      clear_obs();
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL zero_ready: got %b want 1", cmd_ready);
      end
      cmd_count = '0;
      cmd_inc   = 1'b1;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      if (cin !== 2'b00) cin_ok = 1'b0;
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL zero_cycle1: done=%b busy=%b want done=0 busy=1", done, busy);
      end
      @(negedge clk);
      if (cin !== 2'b00) cin_ok = 1'b0;
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL zero_done_cycle2: got %b want 1", done);
      end
      @(negedge clk);
      if (cin !== 2'b00) cin_ok = 1'b0;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL zero_cycle3: done=%b busy=%b want 0 0", done, busy);
      end
      checks++;
      if (!cin_ok || data_cnt != 0) begin
         errors++;
         $display("FAIL zero_cin: cin_ok=%0d wavefronts=%0d want 1 0", cin_ok, data_cnt);
      end
   endtask

   task automatic test_burst(input logic [WIDTH-1:0] start, input int cnt,
                             input bit inc, input string name);
      logic [WIDTH-1:0] exp_w;
      clear_obs();
      model_val = start;
      resp_en   = 1'b1;
      issue(cnt, inc);
      for (int c = 0; c < 3000 && done_cnt == 0; c++) @(negedge clk);
      repeat (6) @(negedge clk);
      resp_en = 1'b0;
      checks++;
      if (done_cnt != 1) begin
         errors++;
         $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt);
      end
      checks++;
      if (data_cnt != cnt) begin
         errors++;
         $display("FAIL %s wavefronts: got %0d want %0d", name, data_cnt, cnt);
      end
      checks++;
      if (obs_words.size() != cnt) begin
         errors++;
         $display("FAIL %s word_count: got %0d want %0d", name, obs_words.size(), cnt);
      end
      exp_w = start;
      for (int k = 0; k < cnt; k++) begin
         exp_w = exp_w + (inc ? 32'd1 : 32'd0);
         if (k < obs_words.size()) begin
            checks++;
            if (obs_words[k] !== exp_w) begin
               errors++;
               $display("FAIL %s word[%0d]: got %h want %h", name, k, obs_words[k], exp_w);
            end
         end
      end
      checks++;
      if (err !== 1'b0 || bad_cin != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s status: err=%b cin11=%0d busy=%b want 0 0 0", name, err, bad_cin, busy);
      end
   endtask

   task automatic test_init_mid_burst();
      clear_obs();
      resp_en = 1'b0;
      issue(2, 1'b1);
      repeat (6) @(negedge clk);
      checks++;
      if (cin !== 2'b10 || busy !== 1'b1) begin
         errors++;
         $display("FAIL init_pre: cin=%b busy=%b want 10 1", cin, busy);
      end
      init = 1'b1;
      #1;
      checks++;
      if (cin !== 2'b00 || busy !== 1'b0 || cmd_ready !== 1'b1 || sum_ack !== '0 ||
          word !== '0 || word_valid !== 1'b0 || err !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL init_async: cin=%b busy=%b rdy=%b sum_ack=%h word=%h wv=%b err=%b done=%b",
                  cin, busy, cmd_ready, sum_ack, word, word_valid, err, done);
      end
      repeat (2) @(negedge clk);
      init = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (done_cnt != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL init_no_done: done_pulses=%0d busy=%b want 0 0", done_cnt, busy);
      end
   endtask

   task automatic test_bad_digit();
      logic [WIDTH-1:0]   v;
      logic [2*WIDTH-1:0] s;
      clear_obs();
      resp_en = 1'b0;
      v   = $urandom | 32'h1;
      sum = dr(v);
      repeat (8) @(negedge clk);
      checks++;
      if (sum_ack !== '1 || err !== 1'b0) begin
         errors++;
         $display("FAIL bad_pre: sum_ack=%h err=%b want ffffffff 0", sum_ack, err);
      end
      checks++;
      if (obs_words.size() != 1 || (obs_words.size() == 1 && obs_words[0] !== v)) begin
         errors++;
         $display("FAIL bad_pre_word: count=%0d want 1 value %h", obs_words.size(), v);
      end
      s = '0;
      s[11:10] = 2'b11;
      sum = s;
      repeat (8) @(negedge clk);
      checks++;
      if (err !== 1'b1 || sum_ack !== 32'h0000_0020) begin
         errors++;
         $display("FAIL bad_digit5: err=%b sum_ack=%h want 1 00000020", err, sum_ack);
      end
      s = dr(~v);
      s[11:10] = 2'b11;
      sum = s;
      repeat (8) @(negedge clk);
      checks++;
      if (sum_ack !== '1 || obs_words.size() != 1) begin
         errors++;
         $display("FAIL bad_others: sum_ack=%h words=%0d want ffffffff 1", sum_ack, obs_words.size());
      end
      sum = '0;
      repeat (8) @(negedge clk);
      checks++;
      if (err !== 1'b1 || sum_ack !== '0) begin
         errors++;
         $display("FAIL bad_sticky: err=%b sum_ack=%h want 1 0", err, sum_ack);
      end
      init = 1'b1;
      repeat (2) @(negedge clk);
      init = 1'b0;
      repeat (4) @(negedge clk);
   endtask

`ifdef NCL_SEQ_TIMEOUT_EN
   task automatic test_timeout();
      int n = 0;
      bit seen = 1'b0;
      resp_en = 1'b0;
      cin_ack = 1'b0;
      issue(1, 1'b0);
      for (int c = 0; c < 20 && !seen; c++) begin
         if (cin != 2'b00) seen = 1'b1;
         else @(negedge clk);
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL timeout_start: cin never left NULL");
      end
      while (busy && n < 5000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n != 4096) begin
         errors++;
         $display("FAIL timeout_cycles: got %0d want 4096", n);
      end
      checks++;
      if (err !== 1'b1 || cin !== 2'b00) begin
         errors++;
         $display("FAIL timeout_state: err=%b cin=%b want 1 00", err, cin);
      end
      init = 1'b1;
      repeat (2) @(negedge clk);
      init = 1'b0;
      repeat (4) @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_zero_count();
      test_burst(32'h0000_0000, 3, 1'b1, "count3");
      test_init_mid_burst();
      test_burst(32'hFFFF_FFFF, 1, 1'b1, "wrap");
      for (int r = 0; r < 4; r++) begin
         test_burst($urandom, int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)), "random");
      end
      test_bad_digit();
`ifdef NCL_SEQ_TIMEOUT_EN
      test_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ncl_counter_sequencer.md
NCL_COUNTER_SEQUENCER -- requirements
Module: ncl_counter_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, 32, number of dual-rail sum digits in the counter.
REQ-002 SHALL have parameter CNT_W, 16, width of the wavefront request count.
REQ-003 SHALL have port clk, input, 1, the single clock; all registers are on its rising edge.
REQ-004 SHALL have port init, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1, a request for a burst of wavefronts.
REQ-006 SHALL have port cmd_ready, output, 1, high only in IDLE.
REQ-007 SHALL have port cmd_count, input, CNT_W, the number of DATA wavefronts to issue; 0 means none.
REQ-008 SHALL have port cmd_inc, input, 1, carry-in value: 1 drives rail1 (increment), 0 drives rail0 (hold).
REQ-009 SHALL have port cin, output, 2, dual-rail carry-in to digit 0: [1]=rail1, [0]=rail0.
REQ-010 SHALL have port cin_ack, input, 1, asynchronous completion from digit 0.
REQ-011 SHALL have port sum, input, 2*WIDTH, dual-rail sum digits; digit i occupies [2i+1:2i].
REQ-012 SHALL have port sum_ack, output, WIDTH, per-digit consume completion.
REQ-013 SHALL have port word_valid, output, 1, one-cycle pulse when a full sum word has been captured.
REQ-014 SHALL have port word, output, WIDTH, the last captured sum word.
REQ-015 SHALL have port busy, output, 1, high in any state except IDLE.
REQ-016 SHALL have port done, output, 1, one-cycle pulse when a burst ends.
REQ-017 SHALL have port err, output, 1, sticky error flag.

Function
REQ-018 SHALL pass cin_ack and every sum rail through a 2-flop synchronizer before use.
REQ-019 SHALL implement the FSM IDLE -> DATA -> WAIT_ACK -> NULL -> WAIT_NACK -> back to DATA while remaining>0, else DONE -> IDLE.
REQ-020 IDLE: on cmd_valid&&cmd_ready, latch cmd_count into remaining and cmd_inc into inc_r; go to DATA, or to DONE if cmd_count==0.
REQ-021 DATA: drive cin={inc_r,~inc_r} for exactly the one cycle of this state and every cycle of WAIT_ACK; go to WAIT_ACK.
REQ-022 WAIT_ACK: on synchronized cin_ack==1, decrement remaining and go to NULL.
REQ-023 NULL and WAIT_NACK: cin=2'b00; leave WAIT_NACK only on synchronized cin_ack==0.
REQ-024 DONE: pulse done for one cycle and return to IDLE.
REQ-025 cin SHALL be registered and SHALL never be 2'b11.
REQ-026 SHALL treat each digit i independently: sum_ack[i] rises when the synchronized digit is DATA (01 or 10), capturing rail1 into cap[i]; sum_ack[i] falls when the digit is NULL (00).
REQ-027 SHALL pulse word_valid and copy cap into word in the cycle after the last of the WIDTH digits has been captured since the previous word_valid.
REQ-028 SHALL set err on any synchronized digit reading 11; the offending digit's sum_ack SHALL hold its value.
REQ-029 SHALL ignore cmd_valid while busy.
REQ-030 Per-digit capture and a word_valid pulse in the same cycle SHALL count the new digit toward the next word.

Reset
REQ-031 While init is high: FSM=IDLE, cin=00, sum_ack=0, word=0, word_valid=0, done=0, err=0, remaining=0, synchronizers=0.
REQ-032 Asserting init mid-burst SHALL abandon the burst with no done pulse.

Configuration
REQ-033 With NCL_SEQ_TIMEOUT_EN defined: a 12-bit watchdog counts cycles in WAIT_ACK or WAIT_NACK; reaching 4095 SHALL set err and force the FSM to IDLE with cin=00.
REQ-034 Without NCL_SEQ_TIMEOUT_EN: no watchdog exists, and the wait states are unbounded.

Structure
REQ-035 Package ncl_seq_pkg SHALL hold the FSM state enum, the dual-rail constants NCL_NULL=00, NCL_D0=01, NCL_D1=10, and the default watchdog limit.
REQ-036 SHALL use one sub-module, ncl_sync2, a 2-flop synchronizer with async reset, instantiated per asynchronous input bit.

Verification
REQ-037 cmd_count=3 and cmd_inc=1 with an ideal counter model -> three DATA/NULL cycles on cin, done once, and word values 1, 2, 3 in that order.
REQ-038 cmd_count=0 -> done is pulsed two cycles after the handshake, and cin stays 00.
REQ-039 Digit 5 is driven to 11 -> err=1, sum_ack[5] holds, and the other digits continue.
REQ-040 init is asserted in WAIT_ACK -> all outputs return to reset values immediately, with no done pulse.
REQ-041 NCL_SEQ_TIMEOUT_EN is defined and cin_ack is held low -> err=1 and the FSM returns to IDLE 4095 cycles after entering WAIT_ACK.
REQ-042 Starting from 32'hFFFFFFFF, one increment -> word=0 and the carry-out completes with no error.
